// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared state encoding, wire constants and CRC-32 helpers for the
// Ethernet transmit framer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    // Bit-reversed form of 0x04C11DB7, for the LSB-first (reflected) shift.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Receiver-side acceptance: register after data+FCS, bit-reversed, equals the magic residue.
    function automatic logic residue_ok(input logic [31:0] crc);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = crc[31-i];
        end
        return r == CRC_RESIDUE;
    endfunction

endpackage

// File: rtl/eth_tx_crc32.sv
// eth_tx_crc32: byte-wide reflected CRC-32 accumulator. fcs is the complemented
// register; fcs[7:0] is the first FCS byte on the wire.
module eth_tx_crc32
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] fcs
);

    logic [31:0] crc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

    assign fcs = ~crc;

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-serial Ethernet transmit framer (preamble, SFD, payload, pad, FCS, IFG).
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_PAYLOAD bytes.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_err,
    output logic       busy
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int          CNT_W        = 8;
    localparam logic [10:0] BYTE_CNT_MAX = 11'h7FF;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [10:0]      byte_cnt, byte_cnt_n, byte_cnt_inc;
    logic             valid_n, sof_n, eof_n, err_n, ready_n;
    logic [7:0]       data_n;
    logic             crc_init, crc_en;
    logic [7:0]       crc_data;
    logic [31:0]      fcs;
    logic [1:0]       fcs_idx;
    logic             tail;

    assign byte_cnt_inc = (byte_cnt == BYTE_CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;

    // The CRC advances on the edge that puts a byte on the wire, so it already
    // covers every driven byte when the first FCS byte is registered.
    eth_tx_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (crc_data),
        .fcs  (fcs)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n    = state;
        cnt_n      = cnt;
        byte_cnt_n = byte_cnt;
        valid_n    = 1'b0;
        data_n     = 8'h00;
        sof_n      = 1'b0;
        eof_n      = 1'b0;
        err_n      = 1'b0;
        ready_n    = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        crc_data   = 8'h00;
        fcs_idx    = 2'd0;
        tail       = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = PRE;
                    cnt_n   = '0;
                    valid_n = 1'b1;
                    data_n  = PREAMBLE_BYTE;
                    sof_n   = 1'b1;
                end
            end
            PRE: begin
                valid_n = 1'b1;
                if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_n    = SFD;
                    data_n     = SFD_BYTE;
                    ready_n    = 1'b1;
                    crc_init   = 1'b1;
                    byte_cnt_n = '0;
                end else begin
                    cnt_n  = cnt + 1'b1;
                    data_n = PREAMBLE_BYTE;
                end
            end
            SFD, DATA: begin
                if (!tx_ready) begin
                    tail = 1'b1;
                end else if (tx_valid) begin
                    state_n    = DATA;
                    valid_n    = 1'b1;
                    data_n     = tx_data;
                    crc_en     = 1'b1;
                    crc_data   = tx_data;
                    byte_cnt_n = byte_cnt_inc;
                    ready_n    = !tx_last;
                end else begin
                    // Upstream starved mid-frame: abandon without FCS so the receiver drops it.
                    state_n = IFG;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end
            end
            PAD: begin
                tail = 1'b1;
            end
            FCS: begin
                if (cnt == CNT_W'(3)) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    fcs_idx = cnt[1:0] + 2'd1;
                    valid_n = 1'b1;
                    data_n  = fcs[{fcs_idx, 3'b000} +: 8];
                    eof_n   = (fcs_idx == 2'd3);
                end
            end
            IFG: begin
                if (cnt == CNT_W'(IFG_BYTES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Payload finished (last byte or a pad byte on the wire): pad further or start the FCS.
        if (tail) begin
            valid_n = 1'b1;
            if (PAD_EN && (byte_cnt < 11'(MIN_PAYLOAD))) begin
                state_n    = PAD;
                crc_en     = 1'b1;
                crc_data   = 8'h00;
                byte_cnt_n = byte_cnt_inc;
            end else begin
                state_n = FCS;
                cnt_n   = '0;
                data_n  = fcs[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_cnt  <= '0;
            tx_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            byte_cnt  <= byte_cnt_n;
            tx_ready  <= ready_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_sof   <= sof_n;
            out_eof   <= eof_n;
            out_err   <= err_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit-side Ethernet framer for the 8-bit serial datapath with preamble and CRC. It accepts a payload byte stream under a valid/ready/last handshake. It emits a complete wire frame of 7×0x55 preamble, 0xD5 SFD, payload, optional zero padding and a 4-byte FCS, then enforces an inter-frame gap. It is the transmitter counterpart of the receiver library's CRC checker: the FCS it appends must make a receiver's CRC residue check pass.

## Interface
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
- MIN_PAYLOAD, 60, minimum bytes between SFD and FCS (DA..payload); shorter frames are padded when padding is enabled
- IFG_BYTES, 12, idle cycles forced after the last FCS byte
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-low reset
- tx_valid  in  1  upstream byte valid
- tx_data  in  8  upstream payload byte
- tx_last  in  1  marks the final payload byte; sampled with tx_valid & tx_ready
- tx_ready  out  1  framer accepts tx_data this cycle
- out_valid  out  1  out_data carries a frame byte
- out_data  out  8  wire byte (preamble, SFD, payload, pad, FCS)
- out_sof  out  1  high with the first preamble byte
- out_eof  out  1  high with the last FCS byte
- out_err  out  1  one-cycle pulse on underrun abort
- busy  out  1  state != IDLE

## Operation
- The state machine has these states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG. The state names the byte being driven on out_data this cycle.
- **IDLE:** when tx_valid=1, go to PRE. The data byte is not consumed.
- **PRE:** drives 0x55 for PREAMBLE_LEN cycles, then goes to SFD.
- **SFD:** drives 0xD5, then goes to DATA.
- **DATA:** the byte accepted in the previous cycle is driven and fed to the CRC.
- **Handshake:** tx_ready=1 in SFD, and in DATA while the byte just driven was not last. A byte is accepted when tx_valid & tx_ready.
- **Underrun:** tx_ready=1 and tx_valid=0 during DATA is an underrun. The framer then:
  - drives out_valid=0;
  - pulses out_err;
  - goes to IFG with no FCS sent.
- **After the last byte:** once the last byte has been driven, go to PAD if count < MIN_PAYLOAD, else FCS.
- **PAD:** drives 0x00 (CRC-included) until count = MIN_PAYLOAD, then goes to FCS.
- **FCS:** drives 4 bytes, fcs[7:0] first, then goes to IFG.
- **IFG:** out_valid=0 for IFG_BYTES cycles, then goes to IDLE. tx_valid is ignored here.
- **CRC-32:**
  - polynomial 0x04C11DB7, reflected;
  - register loaded with 0xFFFFFFFF in SFD and updated in DATA/PAD;
  - FCS = bitwise NOT of the reflected register.
  - Appending the FCS must yield receiver residue 0xC704DD7B.
- **Byte count:** 11 bits, cleared in SFD, incremented per DATA/PAD byte, and saturates at 2047.
- **Reset values:** all outputs 0, state IDLE, CRC register 0xFFFFFFFF, counters 0. Reset mid-frame truncates immediately; no FCS or IFG is emitted afterwards.
- **Last byte plus underrun:** tx_last accepted together with a following tx_valid=0 is not an underrun, because tx_ready is already low.

## Timing
- All outputs are registered.
- Frame start: tx_valid=1 in IDLE at cycle 0.
  - Preamble on cycles 1..7, out_sof on cycle 1.
  - SFD on cycle 8.
  - First accept at cycle 8, that byte on out_data at cycle 9.
- Payload latency is exactly 1 cycle from accept to out_data.
- FCS byte 0 follows the final payload or pad byte with no gap. out_eof is on FCS byte 3.
- Earliest next out_sof is IFG_BYTES+2 cycles after out_eof (IFG, then one IDLE cycle).

## Configuration
- **ETH_TX_PAD_EN defined:** PAD state present. Frames shorter than MIN_PAYLOAD are zero-padded, and the pad bytes are covered by the FCS.
- **ETH_TX_PAD_EN undefined:** PAD is removed and DATA goes directly to FCS. Runt frames are sent as given, and MIN_PAYLOAD is unused.

## Structure
- Package eth_tx_pkg holds:
  - the state enum;
  - the constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hC704DD7B.
- One sub-module, eth_tx_crc32: byte-wide reflected CRC-32 with init and enable inputs, returning the complemented, reflected FCS.
- The framer FSM, counters and output mux live in the top module.

## Test plan
- Macro off, 9-byte payload "123456789" (0x31..0x39) -> out_data 0x55×7, 0xD5, payload, then FCS 0x26,0x39,0xF4,0xCB; 21 valid cycles; out_eof on 0xCB.
- Macro on, same 9 bytes -> 51 zero pad bytes; frame is 72 valid bytes; receiver residue over payload+pad+FCS = 0xC704DD7B.
- 64-byte payload with the macro on -> no PAD; FCS directly after byte 64; IFG of 12 out_valid=0 cycles before the next frame.
- tx_valid dropped after payload byte 20 -> out_err pulses one cycle; no FCS; IFG then IDLE.
- Back-to-back frames with tx_valid held high -> second out_sof exactly 14 cycles after the first out_eof.
- rst low during FCS byte 1 -> all outputs 0 asynchronously; after release, the next frame's FCS is correct (CRC reinitialized).
